// File: rtl/ppm_phase_adjuster.sv
// ppm_phase_adjuster: loop filter plus slot-clock NCO for the PPM receiver.
// Integrates ahead/behind votes from phase_detector and, once the filter
// reaches threshold, stretches or shrinks one slot by a single clk_high cycle.
module ppm_phase_adjuster #(
  parameter int unsigned DIV      = 8,
  parameter int unsigned K        = 4,
  parameter int unsigned LOCK_CNT = 15
) (
  input  logic       clk_high,
  input  logic       rst,
  input  logic       enable,
  input  logic       ahead,
  input  logic       behind,
  output logic       clk_low,
  output logic       slot_strobe,
  output logic [3:0] phase_cnt,
  output logic       adj_stretch,
  output logic       adj_shrink,
  output logic       locked
);

  localparam logic [1:0] PEND_NONE    = 2'd0;
  localparam logic [1:0] PEND_STRETCH = 2'd1;
  localparam logic [1:0] PEND_SHRINK  = 2'd2;

  localparam logic [3:0]        PH_LAST  = 4'(DIV - 1);
  localparam logic [3:0]        PH_PRE   = 4'(DIV - 2);
  localparam logic [3:0]        PH_HALF  = 4'(DIV / 2);
  localparam logic signed [4:0] K_POS    = 5'(K);
  localparam logic signed [4:0] K_NEG    = -K_POS;
  localparam logic signed [3:0] K_SAT_P  = 4'(K);
  localparam logic signed [3:0] K_SAT_N  = -K_SAT_P;
  localparam logic [7:0]        LOCK_MAX = 8'(LOCK_CNT);

  logic              ahead_q, ahead_qq, behind_q, behind_qq;
  logic              a_rise, b_rise, vote_up, vote_dn;
  logic signed [3:0] filt, filt_nx;
  logic signed [4:0] filt_ext, filt_sum, vote_delta;
  logic [1:0]        pending, pend_base, pend_nx;
  logic              hold_q;
  logic              do_stretch, do_shrink;
  logic [3:0]        phase_nx;
  logic              strobe_nx;
  logic [7:0]        lock_cnt, lock_nx;
  logic              adj_seen, seen_nx;

  assign a_rise  = ahead_q & ~ahead_qq;
  assign b_rise  = behind_q & ~behind_qq;
  assign vote_up = enable & a_rise & ~b_rise;
  assign vote_dn = enable & b_rise & ~a_rise;

  // hold_q marks the inserted cycle so a stretch cannot re-trigger in it
  assign do_stretch = enable && (pending == PEND_STRETCH) && (phase_cnt == PH_LAST) && !hold_q;
  assign do_shrink  = enable && (pending == PEND_SHRINK) && (phase_cnt == PH_PRE);

  assign filt_ext = {filt[3], filt};
  assign clk_low  = (phase_cnt < PH_HALF);

  // Signed step applied to the filter for this cycle's vote
  always_comb begin
    vote_delta = '0;
    if (vote_up)      vote_delta = 5'sd1;
    else if (vote_dn) vote_delta = -5'sd1;
  end

  // Next phase: hold at the last phase for a stretch, jump to 0 for a shrink
  always_comb begin
    phase_nx = phase_cnt + 4'd1;
    if (do_stretch)                          phase_nx = PH_LAST;
    else if (do_shrink || phase_cnt == PH_LAST) phase_nx = '0;
    strobe_nx = (phase_nx == '0);
  end

  // Loop filter and pending adjustment; an executing adjustment frees the
  // pending slot first so a coincident threshold hit becomes the next request
  always_comb begin
    filt_sum  = filt_ext + vote_delta;
    pend_base = (do_stretch || do_shrink) ? PEND_NONE : pending;
    filt_nx   = filt_sum[3:0];
    pend_nx   = pend_base;
    if (filt_sum >= K_POS) begin
      if (pend_base == PEND_STRETCH) begin
        filt_nx = K_SAT_P;
      end else if (pend_base == PEND_SHRINK) begin
        pend_nx = PEND_NONE;
        filt_nx = '0;
      end else begin
        pend_nx = PEND_STRETCH;
        filt_nx = '0;
      end
    end else if (filt_sum <= K_NEG) begin
      if (pend_base == PEND_SHRINK) begin
        filt_nx = K_SAT_N;
      end else if (pend_base == PEND_STRETCH) begin
        pend_nx = PEND_NONE;
        filt_nx = '0;
      end else begin
        pend_nx = PEND_SHRINK;
        filt_nx = '0;
      end
    end
    if (!enable) begin
      filt_nx = '0;
      pend_nx = PEND_NONE;
    end
  end

  // Lock counter: a stretch ends its slot one cycle before the strobe, so
  // adj_seen carries "this slot was adjusted" up to that strobe
  always_comb begin
    lock_nx = lock_cnt;
    seen_nx = adj_seen;
    if (!enable) begin
      lock_nx = '0;
      seen_nx = 1'b0;
    end else if (do_stretch || do_shrink) begin
      lock_nx = '0;
      seen_nx = do_stretch;
    end else if (strobe_nx) begin
      seen_nx = 1'b0;
      if (!adj_seen && lock_cnt != LOCK_MAX) lock_nx = lock_cnt + 8'd1;
    end
  end

  // Register all state and outputs
  always_ff @(posedge clk_high) begin
    if (rst) begin
      ahead_q     <= 1'b0;
      ahead_qq    <= 1'b0;
      behind_q    <= 1'b0;
      behind_qq   <= 1'b0;
      filt        <= '0;
      pending     <= PEND_NONE;
      hold_q      <= 1'b0;
      phase_cnt   <= '0;
      slot_strobe <= 1'b0;
      adj_stretch <= 1'b0;
      adj_shrink  <= 1'b0;
      lock_cnt    <= '0;
      adj_seen    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      ahead_q     <= ahead;
      ahead_qq    <= ahead_q;
      behind_q    <= behind;
      behind_qq   <= behind_q;
      filt        <= filt_nx;
      pending     <= pend_nx;
      hold_q      <= do_stretch;
      phase_cnt   <= phase_nx;
      slot_strobe <= strobe_nx;
      adj_stretch <= do_stretch;
      adj_shrink  <= do_shrink;
      lock_cnt    <= lock_nx;
      adj_seen    <= seen_nx;
      locked      <= (lock_nx == LOCK_MAX);
    end
  end

endmodule

// File: tb/tb_ppm_phase_adjuster.sv
// Bench for ppm_phase_adjuster: directed scenarios plus a randomized run,
// every cycle compared against a behavioural model of the slot clock.
module tb_ppm_phase_adjuster;

  localparam int DIV      = 8;
  localparam int K        = 4;
  localparam int LOCK_CNT = 15;

  logic       clk_high = 1'b0;
  logic       rst = 1'b1, enable = 1'b0, ahead = 1'b0, behind = 1'b0;
  logic       clk_low, slot_strobe, adj_stretch, adj_shrink, locked;
  logic [3:0] phase_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  ppm_phase_adjuster #(.DIV(DIV), .K(K), .LOCK_CNT(LOCK_CNT)) dut (
    .clk_high(clk_high), .rst(rst), .enable(enable), .ahead(ahead), .behind(behind),
    .clk_low(clk_low), .slot_strobe(slot_strobe), .phase_cnt(phase_cnt),
    .adj_stretch(adj_stretch), .adj_shrink(adj_shrink), .locked(locked)
  );

  always #5 clk_high = ~clk_high;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Model state: values visible after the most recent edge
  int m_phase, m_hold, m_filt, m_pend, m_lock, m_seen;
  int a1, a2, b1, b2;
  int e_strobe, e_str, e_shr, e_lock;

  task automatic model_step(input bit r, input bit en, input bit a, input bit b);
    int vote, ex_s, ex_k, pend, f, nphase, dir;
    if (r) begin
      m_phase = 0; m_hold = 0; m_filt = 0; m_pend = 0; m_lock = 0; m_seen = 0;
      a1 = 0; a2 = 0; b1 = 0; b2 = 0;
      e_strobe = 0; e_str = 0; e_shr = 0; e_lock = 0;
      return;
    end
    vote = en ? (((a1 == 1 && a2 == 0) ? 1 : 0) - ((b1 == 1 && b2 == 0) ? 1 : 0)) : 0;
    ex_s = (en && m_pend == 1 && m_phase == DIV - 1 && m_hold == 0) ? 1 : 0;
    ex_k = (en && m_pend == -1 && m_phase == DIV - 2) ? 1 : 0;
    pend = (ex_s || ex_k) ? 0 : m_pend;
    f = m_filt + vote;
    if (f >= K || f <= -K) begin
      dir = (f > 0) ? 1 : -1;
      if (pend == dir) f = dir * K;
      else if (pend == -dir) begin pend = 0; f = 0; end
      else begin pend = dir; f = 0; end
    end
    if (!en) begin f = 0; pend = 0; end
    if (ex_s != 0) nphase = DIV - 1;
    else if (ex_k != 0 || m_phase == DIV - 1) nphase = 0;
    else nphase = m_phase + 1;
    e_strobe = (nphase == 0) ? 1 : 0;
    e_str = ex_s;
    e_shr = ex_k;
    if (!en) begin
      m_lock = 0; m_seen = 0;
    end else if (ex_s || ex_k) begin
      m_lock = 0; m_seen = ex_s;
    end else if (e_strobe != 0) begin
      if (m_seen == 0 && m_lock < LOCK_CNT) m_lock++;
      m_seen = 0;
    end
    e_lock = (m_lock == LOCK_CNT) ? 1 : 0;
    m_hold = ex_s; m_phase = nphase; m_filt = f; m_pend = pend;
    a2 = a1; a1 = a; b2 = b1; b1 = b;
  endtask

  task automatic cycle(input bit r, input bit en, input bit a, input bit b);
    rst = r; enable = en; ahead = a; behind = b;
    model_step(r, en, a, b);
    @(posedge clk_high);
    #1;
  endtask

  // Steps nominal cycles until a slot strobe is observed (bounded)
  task automatic align(output bit found);
    found = 1'b0;
    for (int i = 0; i < 2 * DIV && !found; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      if (slot_strobe === 1'b1) found = 1'b1;
    end
  endtask

  function automatic logic [8:0] dut_vec();
    return {phase_cnt, clk_low, slot_strobe, adj_stretch, adj_shrink, locked};
  endfunction

  function automatic logic [8:0] mdl_vec();
    return {4'(m_phase), 1'(m_phase < DIV / 2), 1'(e_strobe), 1'(e_str), 1'(e_shr), 1'(e_lock)};
  endfunction

  function automatic int dut_filt();
    return int'($signed(dut.filt));
  endfunction

  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (dut_vec() !== 9'b0000_1_0_0_0_0) begin
      n_fail++; $display("FAIL reset_state dut=%b required=%b", dut_vec(), 9'b0000_1_0_0_0_0);
    end
    n_checks++;
    if (dut_filt() !== 0) begin n_fail++; $display("FAIL reset_filt dut=%0d required=0", dut_filt()); end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (phase_cnt !== 4'd1 || slot_strobe !== 1'b0) begin
      n_fail++; $display("FAIL reset_first_cycle phase=%0d strobe=%b required phase=1 strobe=0", phase_cnt, slot_strobe);
    end
  endtask

  task automatic test_nominal();
    int strobes = 0, highs = 0, lock_at = -1;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL nominal_cycle i=%0d dut=%h model=%h", i, dut_vec(), mdl_vec());
      end
      if (slot_strobe === 1'b1) strobes++;
      if (clk_low === 1'b1) highs++;
      if (locked === 1'b1 && lock_at < 0) lock_at = strobes;
    end
    n_checks++;
    if (strobes != 25) begin n_fail++; $display("FAIL nominal_strobes got=%0d required=25", strobes); end
    n_checks++;
    if (highs != 100) begin n_fail++; $display("FAIL nominal_clk_low_high got=%0d required=100", highs); end
    n_checks++;
    if (lock_at != 15) begin n_fail++; $display("FAIL nominal_lock_strobe got=%0d required=15", lock_at); end
  endtask

  task automatic test_stretch();
    bit ok;
    int last = 0, n9 = 0, n_odd = 0, n_adj = 0;
    align(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stretch_align no strobe within bound"); end
    for (int i = 1; i <= 30; i++) begin
      cycle(1'b0, 1'b1, (i == 1 || i == 4 || i == 7 || i == 10), 1'b0);
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL stretch_cycle i=%0d dut=%h model=%h", i, dut_vec(), mdl_vec());
      end
      if (adj_stretch === 1'b1) n_adj++;
      if (slot_strobe === 1'b1) begin
        if (i - last == 9) n9++;
        if (i - last != DIV) n_odd++;
        last = i;
      end
    end
    n_checks++;
    if (n_adj != 1 || n9 != 1 || n_odd != 1) begin
      n_fail++; $display("FAIL stretch_period adj=%0d len9=%0d non8=%0d required 1/1/1", n_adj, n9, n_odd);
    end
    n_checks++;
    if (dut_filt() !== 0 || locked !== 1'b0) begin
      n_fail++; $display("FAIL stretch_after filt=%0d locked=%b required 0/0", dut_filt(), locked);
    end
  endtask

  task automatic test_shrink();
    bit ok;
    int last = 0, n7 = 0, n_odd = 0, n_adj = 0, n_apart = 0;
    align(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL shrink_align no strobe within bound"); end
    for (int i = 1; i <= 30; i++) begin
      cycle(1'b0, 1'b1, 1'b0, (i == 1 || i == 4 || i == 7 || i == 10));
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL shrink_cycle i=%0d dut=%h model=%h", i, dut_vec(), mdl_vec());
      end
      if (adj_shrink === 1'b1) begin
        n_adj++;
        if (slot_strobe !== 1'b1) n_apart++;
      end
      if (slot_strobe === 1'b1) begin
        if (i - last == 7) n7++;
        if (i - last != DIV) n_odd++;
        last = i;
      end
    end
    n_checks++;
    if (n_adj != 1 || n7 != 1 || n_odd != 1 || n_apart != 0) begin
      n_fail++; $display("FAIL shrink_period adj=%0d len7=%0d non8=%0d apart=%0d required 1/1/1/0", n_adj, n7, n_odd, n_apart);
    end
  endtask

  task automatic test_cancel();
    bit ok;
    int n_adj = 0, last = 0, n_odd = 0;
    bit a, b;
    for (int i = 1; i <= 40; i++) begin
      cycle(1'b0, 1'b1, (i == 1 || i == 4 || i == 7), (i == 10 || i == 13 || i == 16));
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL cancel_balanced_cycle i=%0d dut=%h model=%h", i, dut_vec(), mdl_vec());
      end
      if (adj_stretch === 1'b1 || adj_shrink === 1'b1) n_adj++;
    end
    n_checks++;
    if (n_adj != 0 || dut_filt() !== 0) begin
      n_fail++; $display("FAIL cancel_balanced adj=%0d filt=%0d required 0/0", n_adj, dut_filt());
    end
    align(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL cancel_align no strobe within bound"); end
    for (int i = 1; i <= 30; i++) begin
      a = (i == 1 || i == 3 || i == 5 || i == 7);
      b = (i == 8 || i == 10 || i == 12 || i == 14);
      cycle(1'b0, 1'b1, a, b);
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL cancel_pending_cycle i=%0d dut=%h model=%h", i, dut_vec(), mdl_vec());
      end
      if (adj_stretch === 1'b1 || adj_shrink === 1'b1) n_adj++;
      if (slot_strobe === 1'b1) begin
        if (i - last != DIV) n_odd++;
        last = i;
      end
    end
    n_checks++;
    if (n_adj != 0 || n_odd != 0 || dut_filt() !== 0) begin
      n_fail++; $display("FAIL cancel_pending adj=%0d non8=%0d filt=%0d required 0/0/0", n_adj, n_odd, dut_filt());
    end
  endtask

  task automatic test_same_cycle();
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (dut_filt() !== 0) begin n_fail++; $display("FAIL same_cycle_filt dut=%0d required=0", dut_filt()); end
    for (int i = 0; i < 24; i++) begin
      cycle(1'b0, 1'b1, (i < 20), 1'b0);
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL held_level_cycle i=%0d dut=%h model=%h", i, dut_vec(), mdl_vec());
      end
    end
    n_checks++;
    if (dut_filt() !== 1) begin n_fail++; $display("FAIL held_level_filt dut=%0d required=1", dut_filt()); end
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (dut_filt() !== 0) begin n_fail++; $display("FAIL behind_vote_filt dut=%0d required=0", dut_filt()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int first = -1, n_adj = 0;
    align(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL reset_mid_align no strobe within bound"); end
    for (int i = 1; i <= 13; i++) cycle(1'b0, 1'b1, (i == 1 || i == 3 || i == 5 || i == 7), 1'b0);
    n_checks++;
    if (phase_cnt !== 4'd5) begin n_fail++; $display("FAIL reset_mid_phase dut=%0d required=5", phase_cnt); end
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (phase_cnt !== 4'd0 || slot_strobe !== 1'b0 || dut_filt() !== 0) begin
      n_fail++; $display("FAIL reset_mid_state phase=%0d strobe=%b filt=%0d required 0/0/0", phase_cnt, slot_strobe, dut_filt());
    end
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL reset_mid_cycle i=%0d dut=%h model=%h", i, dut_vec(), mdl_vec());
      end
      if (slot_strobe === 1'b1 && first < 0) first = i;
      if (adj_stretch === 1'b1) n_adj++;
    end
    n_checks++;
    if (first != DIV || n_adj != 0) begin
      n_fail++; $display("FAIL reset_mid_slot first_strobe=%0d adj=%0d required 8/0", first, n_adj);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int strobes = 0;
    align(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL enable_align no strobe within bound"); end
    for (int i = 1; i <= 12; i++) cycle(1'b0, 1'b1, (i == 1 || i == 4 || i == 7), 1'b0);
    n_checks++;
    if (dut_filt() !== 3) begin n_fail++; $display("FAIL enable_prefilt dut=%0d required=3", dut_filt()); end
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b0, (i == 2), 1'b0);
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL enable_off_cycle i=%0d dut=%h model=%h", i, dut_vec(), mdl_vec());
      end
      if (slot_strobe === 1'b1) strobes++;
      if (i == 1) begin
        n_checks++;
        if (dut_filt() !== 0) begin n_fail++; $display("FAIL enable_off_filt dut=%0d required=0", dut_filt()); end
      end
    end
    n_checks++;
    if (strobes != 2 || locked !== 1'b0 || dut_filt() !== 0) begin
      n_fail++; $display("FAIL enable_off_run strobes=%0d locked=%b filt=%0d required 2/0/0", strobes, locked, dut_filt());
    end
  endtask

  task automatic test_random();
    bit en = 1'b1, r, a, b;
    int mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) mode = int'($urandom % 3);
      if ($urandom % 250 == 0) en = !en;
      r = ($urandom % 800 == 0);
      a = (mode == 0) ? ($urandom % 3 == 0) : ($urandom % 10 == 0);
      b = (mode == 1) ? ($urandom % 3 == 0) : ($urandom % 10 == 0);
      cycle(r, en, a, b);
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL random_cycle i=%0d dut=%h model=%h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  initial begin
    @(posedge clk_high);
    #1;
    test_reset();
    test_nominal();
    test_stretch();
    test_shrink();
    test_cancel();
    test_same_cycle();
    test_reset_mid();
    test_enable_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
